ov7670_capture: RTL and testbench
=================================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 Parameters, one per line:
- c_img_cols, 128, stored pixels per line.
- c_img_rows, 128, stored lines per frame.
- c_nb_img_pxls, 14, address width.
- c_nb_buf, 12, buffer word width (RGB444).
REQ-002 Ports, one per line:
- clk, input, 1, system clock; the only clock.
- rst, input, 1, asynchronous, active-high reset.
- cam_pclk, input, 1, camera pixel clock, sampled as data.
- cam_vsync, input, 1, camera frame sync (high = blanking).
- cam_href, input, 1, camera line valid.
- cam_data, input, 8, camera byte.
- wea, output, 1, buffer write enable.
- addra, output, c_nb_img_pxls, buffer write address.
- dina, output, c_nb_buf, buffer write data {R4,G4,B4}.
- frame_done, output, 1, one-cycle pulse at end of a captured frame.
- busy, output, 1, high while state is ACTIVE.

Function
REQ-003 cam_pclk, cam_vsync, cam_href and cam_data SHALL each pass through the same two-flop synchronizer, keeping them cycle-aligned.
REQ-004 The block SHALL register one further copy of synchronized pclk and detect a rising edge as sync=1 and prev=0. Only the synchronized href, vsync and data SHALL be used at that edge.
REQ-005 clk SHALL be at least 4x the cam_pclk frequency. Behaviour below that ratio is unspecified.
REQ-006 FSM states SHALL be WAIT_VS_HI, WAIT_VS_LO and ACTIVE.
- Reset state: WAIT_VS_HI.
- WAIT_VS_HI -> WAIT_VS_LO on synchronized vsync=1.
- WAIT_VS_LO -> ACTIVE on synchronized vsync=0.
- ACTIVE -> WAIT_VS_LO on synchronized vsync=1, with frame_done=1 for exactly one cycle.
REQ-007 In ACTIVE, a byte-phase flag SHALL clear on each synchronized href rising edge. The flag SHALL toggle on each pclk rising edge that occurs while href=1.
REQ-008 Phase 0 byte SHALL be held as {R[4:0],G[5:3]}. Phase 1 byte is {G[2:0],B[4:0]}.
REQ-009 On a phase-1 edge, dina SHALL be {R[4:1],G[5:2],B[4:1]}.
REQ-010 wea SHALL be high for exactly one clk on a phase-1 edge, and only when col < c_img_cols and row < c_img_rows.
REQ-011 wea SHALL rise 3 clk cycles after the first clk edge that samples cam_pclk high, and SHALL fall the following cycle.
REQ-012 Pixels with col >= c_img_cols or row >= c_img_rows SHALL be discarded; counters still advance.
REQ-013 The col counter SHALL:
- increment after every phase-1 edge;
- reset to 0 on href falling edge;
- saturate at c_img_cols rather than wrap.
REQ-014 The row counter SHALL increment on each href falling edge in ACTIVE, saturating at c_img_rows. It SHALL reset to 0 on entry to ACTIVE.
REQ-015 addra SHALL equal row*c_img_cols + col of the written pixel. This is produced by a running address counter reset on ACTIVE entry, not a multiplier.
REQ-016 addra and dina SHALL hold their last values while wea=0.
REQ-017 A href falling edge after a phase-0 byte (odd byte count) SHALL drop that byte without writing.
REQ-018 A vsync rise mid-line SHALL abort the line, pulse frame_done, and leave all prior writes intact.
REQ-019 If frame_done would be generated and a new vsync fall arrives in the same cycle, frame_done SHALL still pulse; ACTIVE is re-entered only after the next WAIT_VS_LO exit.

Reset
REQ-020 While rst=1, outputs SHALL be:
- wea=0, frame_done=0, busy=0;
- addra=0, dina=0;
- state=WAIT_VS_HI;
- all counters, flags and synchronizer flops 0.
REQ-021 Reset SHALL take effect asynchronously. Release SHALL take effect on the next clk edge.
REQ-022 Deassertion mid-frame SHALL discard the remainder of that frame; capture starts at the next full vsync pulse.

Verification
REQ-023 Bench SHALL cover the following scenarios:
- Nominal frame: clk=4x pclk; vsync pulse, 128 lines x 256 bytes -> 16384 writes, addra 0..16383 in order, one frame_done, busy low afterward.
- Pixel packing: byte0=0xF8, byte1=0x1F (R=31,G=0,B=31) -> dina=0xF0F. Bytes 0x07,0xE0 (G=63) -> dina=0x0F0.
- Cropping: 320 px x 240 lines -> exactly 16384 writes. No write with col>=128 or row>=128. Last addra=16383.
- Odd bytes: line of 257 bytes -> 128 writes, trailing byte dropped. Next line starts at addra=128*(row).
- Mid-line vsync: vsync rises at line 5, pixel 40 -> frame_done pulse, last addra=5*128+39, no further writes until next vsync fall.
- Reset mid-frame: rst pulsed during line 10 -> outputs zero immediately. No writes until vsync high then low. Next frame starts at addra=0.

Source files
------------

// File: rtl/ov7670_capture.sv
// ov7670_capture: samples an OV7670 RGB565 byte stream in the clk domain
// and writes cropped RGB444 pixels into a frame buffer port.
`default_nettype none

module ov7670_capture #(
  parameter int c_img_cols    = 128,
  parameter int c_img_rows    = 128,
  parameter int c_nb_img_pxls = 14,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_pclk,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_data,
  output logic                     wea,
  output logic [c_nb_img_pxls-1:0] addra,
  output logic [c_nb_buf-1:0]      dina,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int CW = $clog2(c_img_cols + 1);
  localparam int RW = $clog2(c_img_rows + 1);
  localparam logic [CW-1:0]            c_cols      = CW'(c_img_cols);
  localparam logic [RW-1:0]            c_rows      = RW'(c_img_rows);
  localparam logic [c_nb_img_pxls-1:0] c_line_step = c_nb_img_pxls'(c_img_cols);

  localparam logic [1:0] WAIT_VS_HI = 2'd0;
  localparam logic [1:0] WAIT_VS_LO = 2'd1;
  localparam logic [1:0] ACTIVE     = 2'd2;

  logic [10:0] sync1, sync2;
  logic        pclk_prev, pclk_rise, vsync_q, href_q, href_prev;
  logic [7:0]  data_q;
  logic [1:0]  state;
  logic        phase;
  logic [7:0]  hi_byte;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [c_nb_img_pxls-1:0] line_base, addr_cnt;
  logic        href_rise, href_fall;
  logic        unused_bits;

  // All camera lines share one synchronizer so they stay cycle-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {cam_pclk, cam_vsync, cam_href, cam_data};
      sync2 <= sync1;
    end
  end

  // Edge detect, with href/vsync/data delayed alongside so they line up with pclk_rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_prev <= 1'b0;
      pclk_rise <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      href_prev <= 1'b0;
      data_q    <= '0;
    end else begin
      pclk_prev <= sync2[10];
      pclk_rise <= sync2[10] & ~pclk_prev;
      vsync_q   <= sync2[9];
      href_q    <= sync2[8];
      href_prev <= href_q;
      data_q    <= sync2[7:0];
    end
  end

  assign href_rise   = href_q & ~href_prev;
  assign href_fall   = ~href_q & href_prev;
  assign busy        = (state == ACTIVE);
  assign unused_bits = ^{hi_byte[3], data_q[6:5], data_q[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_VS_HI;
      wea        <= 1'b0;
      frame_done <= 1'b0;
      addra      <= '0;
      dina       <= '0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      col        <= '0;
      row        <= '0;
      line_base  <= '0;
      addr_cnt   <= '0;
    end else begin
      wea        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        WAIT_VS_HI: if (vsync_q) state <= WAIT_VS_LO;
        WAIT_VS_LO: begin
          if (!vsync_q) begin
            state     <= ACTIVE;
            phase     <= 1'b0;
            col       <= '0;
            row       <= '0;
            line_base <= '0;
            addr_cnt  <= '0;
          end
        end
        ACTIVE: begin
          if (vsync_q) begin
            state      <= WAIT_VS_LO;
            frame_done <= 1'b1;
          end else if (href_fall) begin
            // A pending phase-0 byte is simply forgotten here.
            phase <= 1'b0;
            col   <= '0;
            if (row < c_rows) begin
              row       <= row + 1'b1;
              line_base <= line_base + c_line_step;
              addr_cnt  <= line_base + c_line_step;
            end
          end else if (pclk_rise && href_q) begin
            if (!phase || href_rise) begin
              hi_byte <= data_q;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col < c_cols && row < c_rows) begin
                wea   <= 1'b1;
                addra <= addr_cnt;
                dina  <= {hi_byte[7:4], hi_byte[2:0], data_q[7], data_q[4:1]};
              end
              if (col < c_cols) begin
                col      <= col + 1'b1;
                addr_cnt <= addr_cnt + 1'b1;
              end
            end
          end else if (href_rise) begin
            phase <= 1'b0;
          end
        end
        default: state <= WAIT_VS_HI;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_capture.sv
// tb_ov7670_capture: randomized camera stream against a scoreboard of expected
// buffer writes, plus table-driven pixel packing and hand-timed corner cases.
`default_nettype none

module tb_ov7670_capture;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int AW   = 7;
  localparam int BW   = 12;

  logic          clk, rst;
  logic          cam_pclk, cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic          wea, frame_done, busy;
  logic [AW-1:0] addra;
  logic [BW-1:0] dina;

  ov7670_capture #(
    .c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_img_pxls(AW), .c_nb_buf(BW)
  ) dut (
    .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .wea(wea), .addra(addra),
    .dina(dina), .frame_done(frame_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [BW-1:0] dina;
  } pack_vec_t;

  wr_t       expq[$];
  wr_t       mon_e;
  pack_vec_t tbl[6];
  logic [7:0] lb[64];
  int   checks, errors;
  int   nwr, nfd, nbusy;
  int   last_addr;
  bit   exp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: RGB565 fields recovered arithmetically, each reduced to 4 bits.
  function automatic logic [BW-1:0] pack(input logic [7:0] b0, input logic [7:0] b1);
    int r, g, b;
    r = int'(b0) >> 3;
    g = ((int'(b0) & 7) << 3) | (int'(b1) >> 5);
    b = int'(b1) & 31;
    return {4'(r >> 1), 4'(g >> 2), 4'(b >> 1)};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (wea) begin
        nwr++;
        last_addr = int'(addra);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addra=%0d dina=%03h, required no write", addra, dina);
        end else begin
          mon_e = expq.pop_front();
          check("addra", 32'(addra), 32'(mon_e.addr));
          check("dina", 32'(dina), 32'(mon_e.data));
        end
      end
      if (frame_done) nfd++;
      if (busy) nbusy++;
    end
  end

  // One pclk period = 4 clk: 2 low, 2 high; signals change while pclk is low.
  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    cam_vsync = v; cam_href = h; cam_data = d; cam_pclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    repeat (4) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_wea", 32'(wea), 0);
    check("rst_async_addra", 32'(addra), 0);
    check("rst_async_dina", 32'(dina), 0);
    check("rst_async_busy", 32'(busy), 0);
    expq.delete();
    exp_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_line(input int row, input int nbytes, input int stop_at,
                           input int rst_at, input bit push_exp);
    int npix;
    npix = ((stop_at >= 0) ? stop_at : nbytes) / 2;
    if (push_exp)
      for (int p = 0; p < npix; p++)
        if (p < COLS && row < ROWS)
          expq.push_back('{addr: AW'(row * COLS + p), data: pack(lb[2*p], lb[2*p+1])});
    for (int i = 0; i < nbytes; i++) begin
      if (i == stop_at) begin
        repeat (4) cyc(1'b1, 1'b1, 8'($urandom));
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        return;
      end
      if (i == rst_at) do_reset();
      cyc(1'b0, 1'b1, lb[i]);
    end
    repeat (3) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic frame_start();
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_frame(input int nlines, input int nbytes, input int abort_line,
                            input int abort_byte, input int rst_line, input int rst_byte);
    frame_start();
    for (int r = 0; r < nlines; r++) begin
      for (int i = 0; i < nbytes; i++) lb[i] = 8'($urandom);
      send_line(r, nbytes, (r == abort_line) ? abort_byte : -1,
                (r == rst_line) ? rst_byte : -1, exp_en);
      if (r == abort_line) break;
    end
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic frame_checks(input string tag, input int w0, input int f0,
                              input int exp_w, input int exp_f, input int exp_last);
    check({tag, "_writes"}, 32'(nwr - w0), 32'(exp_w));
    check({tag, "_frame_done"}, 32'(nfd - f0), 32'(exp_f));
    check({tag, "_pending"}, 32'(expq.size()), 0);
    check({tag, "_busy_after"}, 32'(busy), 0);
    if (exp_last >= 0) begin
      check({tag, "_last_addr"}, 32'(last_addr), 32'(exp_last));
      check({tag, "_addra_hold"}, 32'(addra), 32'(exp_last));
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, f0, b0;
    logic [7:0] x0, x1;
    tbl[0] = '{8'hF8, 8'h1F, 12'hF0F};
    tbl[1] = '{8'h07, 8'hE0, 12'h0F0};
    tbl[2] = '{8'h00, 8'h00, 12'h000};
    tbl[3] = '{8'hFF, 8'hFF, 12'hFFF};
    tbl[4] = '{8'hA5, 8'h3C, 12'hAAE};
    tbl[5] = '{8'h12, 8'h34, 12'h14A};
    checks = 0; errors = 0; nwr = 0; nfd = 0; nbusy = 0; last_addr = -1;
    exp_en = 1'b1;
    rst = 1'b1;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_wea", 32'(wea), 0);
    check("reset_frame_done", 32'(frame_done), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_addra", 32'(addra), 0);
    check("reset_dina", 32'(dina), 0);
    rst = 1'b0;

    // Write latency: wea rises on the 4th posedge counting the one that samples pclk high.
    w0 = nwr; f0 = nfd;
    x0 = 8'($urandom); x1 = 8'($urandom);
    frame_start();
    expq.push_back('{addr: '0, data: pack(x0, x1)});
    cyc(1'b0, 1'b1, x0);
    @(negedge clk);
    cam_href = 1'b1; cam_data = x1; cam_pclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cam_pclk = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency_wea_early", 32'(wea), 0);
    @(posedge clk);
    #1 check("latency_wea_rise", 32'(wea), 1);
    check("latency_addra", 32'(addra), 0);
    check("latency_dina", 32'(dina), 32'(pack(x0, x1)));
    @(posedge clk);
    #1 check("latency_wea_fall", 32'(wea), 0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    frame_checks("latency", w0, f0, 1, 1, 0);

    // Table-driven packing: one 2-byte line per entry.
    w0 = nwr; f0 = nfd;
    frame_start();
    for (int i = 0; i < 6; i++) begin
      lb[0] = tbl[i].b0;
      lb[1] = tbl[i].b1;
      expq.push_back('{addr: AW'(i * COLS), data: tbl[i].dina});
      send_line(i, 2, -1, -1, 1'b0);
    end
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    frame_checks("pack", w0, f0, 6, 1, 5 * COLS);

    w0 = nwr; f0 = nfd; b0 = nbusy;
    send_frame(ROWS, 2 * COLS, -1, 0, -1, 0);
    frame_checks("nominal", w0, f0, ROWS * COLS, 1, ROWS * COLS - 1);
    check("nominal_busy_seen", 32'(nbusy > b0), 1);

    w0 = nwr; f0 = nfd;
    send_frame(ROWS + 4, 2 * COLS + 8, -1, 0, -1, 0);
    frame_checks("crop", w0, f0, ROWS * COLS, 1, ROWS * COLS - 1);

    w0 = nwr; f0 = nfd;
    send_frame(ROWS, 2 * COLS + 1, -1, 0, -1, 0);
    frame_checks("odd", w0, f0, ROWS * COLS, 1, ROWS * COLS - 1);

    w0 = nwr; f0 = nfd;
    send_frame(ROWS, 2 * COLS, 5, 12, -1, 0);
    frame_checks("abort", w0, f0, 5 * COLS + 6, 1, 5 * COLS + 5);

    w0 = nwr; f0 = nfd;
    send_frame(ROWS, 2 * COLS, -1, 0, 3, 6);
    check("rst_frame_writes", 32'(nwr - w0), 32'(3 * COLS + 3));
    check("rst_frame_done", 32'(nfd - f0), 0);
    exp_en = 1'b1;

    w0 = nwr; f0 = nfd;
    send_frame(ROWS, 2 * COLS, -1, 0, -1, 0);
    frame_checks("after_rst", w0, f0, ROWS * COLS, 1, ROWS * COLS - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
